rf_scan: RTL

RF_SCAN -- requirements
Module: rf_scan

---
 rtl/rf_dbg_pkg.sv | 12 +
 rtl/rf_scan_if.sv | 29 ++
 rtl/rf_scan_edge_rise.sv | 19 +
 rtl/rf_scan.sv | 114 +++++++++++
 4 files changed

// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug scanner and related board blocks.
package rf_dbg_pkg;
  localparam int NUM_REGS            = 32;
  localparam int IDX_W               = $clog2(NUM_REGS);
  localparam int STEP_CYCLES_DEFAULT = 50_000_000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_HOLD = 2'd2
  } scan_state_t;
endpackage

// File: rtl/rf_scan_if.sv
// Read-port and display bus of the register-file scanner; master = scanner side.
interface rf_scan_if;
  import rf_dbg_pkg::*;

  logic [IDX_W-1:0] rf_addr_o;
  logic [31:0]      rf_data_i;
  logic [IDX_W-1:0] disp_idx_o;
  logic [31:0]      disp_data_o;
  logic             disp_valid_o;
  logic             wrap_o;

  modport master (
    output rf_addr_o,
    input  rf_data_i,
    output disp_idx_o,
    output disp_data_o,
    output disp_valid_o,
    output wrap_o
  );

  modport slave (
    input  rf_addr_o,
    output rf_data_i,
    input  disp_idx_o,
    input  disp_data_o,
    input  disp_valid_o,
    input  wrap_o
  );
endinterface

// File: rtl/rf_scan_edge_rise.sv
// Registered rising-edge detector for debounced board buttons; history clears on reset.
module edge_rise (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);
  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= 1'b0;
      rise_o <= 1'b0;
    end else begin
      d_q    <= d_i;
      rise_o <= d_i & ~d_q;
    end
  end
endmodule

// File: rtl/rf_scan.sv
// Walks a free register-file read port over x0..x31 and latches one register at a time
// for display; advance is timed (auto_i) or driven by step_i rising edges.
module rf_scan import rf_dbg_pkg::*; #(
  parameter int STEP_CYCLES = STEP_CYCLES_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          auto_i,
  input  logic          step_i,
  rf_scan_if.master     bus,
  output scan_state_t   state_o
);
  localparam int               TICK_W    = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_REGS - 1);

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [TICK_W-1:0] tick_q;
  logic             hit_q;
  logic             auto_q;
  logic             in_hold_q;
  logic             step_rise;
  logic             auto_chg;
  logic             step_ok;
  logic             advance;

  edge_rise u_step_edge (
    .clk    (clk),
    .rst    (rst),
    .d_i    (step_i),
    .rise_o (step_rise)
  );

  // Valid/ready is not used here: the display bus is a registered snapshot, and
  // disp_valid_o marks cycles where disp_idx_o and disp_data_o belong together.
  // A step edge counts only if it was sampled on an edge taken while already in HOLD.
  assign auto_chg = auto_i ^ auto_q;
  assign step_ok  = step_rise & in_hold_q;

  always_comb begin
    advance = 1'b0;
    if (state_q == ST_HOLD && en_i && !auto_chg)
      advance = auto_i ? hit_q : step_ok;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!en_i) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ADDR;
        ST_ADDR: state_d = ST_HOLD;
        ST_HOLD: if (advance) state_d = ST_ADDR;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q            <= '0;
      tick_q           <= '0;
      hit_q            <= 1'b0;
      auto_q           <= 1'b0;
      in_hold_q        <= 1'b0;
      bus.rf_addr_o    <= '0;
      bus.disp_idx_o   <= '0;
      bus.disp_data_o  <= '0;
      bus.disp_valid_o <= 1'b0;
      bus.wrap_o       <= 1'b0;
    end else begin
      auto_q     <= auto_i;
      in_hold_q  <= (state_q == ST_HOLD);
      hit_q      <= 1'b0;
      bus.wrap_o <= 1'b0;
      if (!en_i || state_q == ST_IDLE) begin
        // Display data is deliberately kept so the last value stays readable.
        idx_q            <= '0;
        tick_q           <= '0;
        bus.rf_addr_o    <= '0;
        bus.disp_valid_o <= 1'b0;
      end else if (state_q == ST_ADDR) begin
        bus.disp_data_o  <= bus.rf_data_i;
        bus.disp_idx_o   <= idx_q;
        bus.disp_valid_o <= 1'b1;
        tick_q           <= '0;
      end else if (state_q == ST_HOLD) begin
        if (advance) begin
          idx_q            <= idx_q + 1'b1;
          bus.rf_addr_o    <= idx_q + 1'b1;
          bus.disp_valid_o <= 1'b0;
          bus.wrap_o       <= (idx_q == IDX_LAST);
          tick_q           <= '0;
        end else if (auto_chg) begin
          tick_q <= '0;
        end else if (auto_i) begin
          // The hit is registered, so the period is STEP_CYCLES+1 HOLD cycles plus ADDR.
          tick_q <= (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
          hit_q  <= (tick_q == TICK_LAST);
        end
      end
    end
  end
endmodule
